proc_ctrl_param: RTL and testbench
==================================

// Module: proc_ctrl_param
// PURPOSE
//  Parametrised control FSM for the simple bus processor. Fetches one instruction
//  from DIN on Run and sequences one-hot bus-drive and register-load strobes for the
//  datapath (register file, A, G, ALU, DIN mux), then asserts Done.
//  Generalises register count and data width; adds mvnz, and, illegal-opcode flag
//  and a retired-instruction counter.
// PARAMETERS
//  REG_AW  3   register-address bits; NUM_REGS = 2**REG_AW
//  DATA_W  9   DIN width; must be >= IW = 3 + 2*REG_AW
//  CNT_W   8   width of retired-instruction counter
// PORTS
//  Clock    in   1         rising-edge clock
//  Resetn   in   1         asynchronous active-low reset
//  DIN      in   DATA_W    instruction in T0, immediate in T1 (mvi)
//  Run      in   1         start request, sampled only in T0
//  Gnz      in   1         datapath flag: G register != 0
//  IRin     out  1         IR load strobe (= Run while in T0)
//  Rout     out  NUM_REGS  one-hot register bus drive, bit i = Ri
//  Gout     out  1         G drives bus
//  DINout   out  1         DIN drives bus
//  Rin      out  NUM_REGS  one-hot register load, bit i = Ri
//  Ain      out  1         load A from bus
//  Gin      out  1         load G from ALU
//  AluOp    out  2         00 add, 01 sub, 10 and, 11 unused
//  Done     out  1         final cycle of instruction
//  Illegal  out  1         pulses with Done on undefined opcode
//  InstrCnt out  CNT_W     count of Done cycles, wraps to 0
// BEHAVIOUR
//  - IR fields: op=IR[IW-1:IW-3], X=IR[IW-4:REG_AW], Y=IR[REG_AW-1:0]; IR loaded
//    from DIN[IW-1:0] on the edge leaving T0 when Run=1.
//  - Opcodes: 000 mv, 001 add, 010 sub, 011 mvi, 100 mvnz, 101 and, 110/111 illegal.
//  - One-hot state T0..T3; outputs combinational from state+IR (IRin also from Run).
//  - T0: all strobes 0; IRin=Run; Run=1 -> T1 else stay.
//  - T1: mv: Rout[Y],Rin[X],Done -> T0. mvi: DINout,Rin[X],Done -> T0.
//        mvnz: if Gnz then Rout[Y],Rin[X]; Done always -> T0.
//        add/sub/and: Rout[X],Ain -> T2. illegal: Done,Illegal, no loads -> T0.
//  - T2 (ALU ops): Rout[Y],Gin,AluOp per opcode -> T3.
//  - T3 (ALU ops): Gout,Rin[X],Done -> T0.
//  - Latency: mv/mvi/mvnz/illegal 2 cycles incl. fetch; add/sub/and 4 cycles.
//  - At most one bus driver (Rout|Gout|DINout) asserted per cycle; Rin one-hot or 0.
//  - AluOp is 00 in every cycle except T2.
//  - Run ignored outside T0; back-to-back: Run held 1 refetches the cycle after Done.
//  - X==Y legal (add R2,R2 doubles R2). Invalid state encoding -> T0 next edge.
//  - InstrCnt += 1 on each edge where Done=1 (illegal counted); 2**CNT_W-1 wraps to 0.
//  - Reset (async, any state): state=T0, IR=0, InstrCnt=0; all outputs 0 immediately
//    except IRin follows Run. Aborted instruction is neither done nor counted.
// TESTING (REG_AW=3, DATA_W=9, CNT_W=4)
//  - mv R1,R2: DIN=9'b000_001_010, Run=1 -> T1: Rout=8'h04, Rin=8'h02, Done=1, InstrCnt 0->1.
//  - add R3,R4: DIN=9'b001_011_100 -> T1 Rout=8'h08,Ain; T2 Rout=8'h10,Gin,AluOp=00;
//    T3 Gout,Rin=8'h08,Done. Repeat sub (010) and and (101) -> AluOp 01 / 10.
//  - mvi R5: DIN=9'b011_101_000 then DIN=9'h0A5 in T1 -> DINout=1, Rin=8'h20, Done.
//  - mvnz R6,R7 with Gnz=0 -> Rin=0, Rout=0, Done=1; Gnz=1 -> Rout=8'h80, Rin=8'h40.
//  - DIN=9'b111_000_000 -> T1: Illegal=1, Done=1, Rin=0, Ain=Gin=0; back in T0 next cycle.
//  - Resetn low during T2 of add -> all strobes 0 same cycle, InstrCnt=0; after release
//    Run with mv R0,R1 completes normally. 16 Run-held mvs -> InstrCnt wraps to 0.

Source files
------------

// File: rtl/proc_ctrl_param.sv
// proc_ctrl_param: one-hot T0..T3 control FSM for the simple bus processor, with illegal-opcode flag and retired-instruction counter
module proc_ctrl_param #(
  parameter int REG_AW = 3,
  parameter int DATA_W = 9,
  parameter int CNT_W = 8,
  localparam int NUM_REGS = 2 ** REG_AW
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                Run,
  input  logic                Gnz,
  output logic                IRin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                Gout,
  output logic                DINout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Ain,
  output logic                Gin,
  output logic [1:0]          AluOp,
  output logic                Done,
  output logic                Illegal,
  output logic [CNT_W-1:0]    InstrCnt
);
  localparam int IW = 3 + 2 * REG_AW;
  localparam logic [NUM_REGS-1:0] ONE = 1;
  localparam logic [2:0] MV = 3'b000, ADD = 3'b001, SUB = 3'b010, MVI = 3'b011,
                         MVNZ = 3'b100, AND = 3'b101;
  typedef enum logic [3:0] {T0 = 4'b0001, T1 = 4'b0010, T2 = 4'b0100, T3 = 4'b1000} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ir;
  logic [2:0] op;
  logic [REG_AW-1:0] x, y;
  logic [NUM_REGS-1:0] rx, ry;
  logic alu;
  assign op = ir[IW-1 -: 3];
  assign x = ir[IW-4 -: REG_AW];
  assign y = ir[REG_AW-1:0];
  assign rx = ONE << x;
  assign ry = ONE << y;
  assign alu = op == ADD || op == SUB || op == AND;
  always_comb begin
    IRin = state == T0 && Run;
    Rout = '0;
    Gout = 1'b0;
    DINout = 1'b0;
    Rin = '0;
    Ain = 1'b0;
    Gin = 1'b0;
    AluOp = 2'b00;
    Done = 1'b0;
    Illegal = 1'b0;
    state_nx = T0;
    case (state)
      T0: state_nx = Run ? T1 : T0;
      T1: begin
        state_nx = alu ? T2 : T0;
        Done = !alu;
        case (op)
          MV: begin
            Rout = ry;
            Rin = rx;
          end
          MVI: begin
            DINout = 1'b1;
            Rin = rx;
          end
          MVNZ: begin
            Rout = Gnz ? ry : '0;
            Rin = Gnz ? rx : '0;
          end
          ADD, SUB, AND: begin
            Rout = rx;
            Ain = 1'b1;
          end
          default: Illegal = 1'b1;
        endcase
      end
      T2: begin
        state_nx = T3;
        Rout = ry;
        Gin = 1'b1;
        AluOp = op == SUB ? 2'b01 : op == AND ? 2'b10 : 2'b00;
      end
      T3: begin
        Gout = 1'b1;
        Rin = rx;
        Done = 1'b1;
      end
      default: state_nx = T0;
    endcase
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir <= '0;
      InstrCnt <= '0;
    end else begin
      state <= state_nx;
      if (IRin) ir <= DIN[IW-1:0];
      if (Done) InstrCnt <= InstrCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_proc_ctrl_param.sv
// tb_proc_ctrl_param: random instruction stream checked cycle by cycle against a per-instruction step model
module tb_proc_ctrl_param;
  localparam int RA = 3, DW = 9, CW = 4, NR = 8;
  logic Clock = 1'b0, Resetn, Run, Gnz;
  logic [DW-1:0] DIN;
  logic IRin, Gout, DINout, Ain, Gin, Done, Illegal;
  logic [NR-1:0] Rout, Rin;
  logic [1:0] AluOp;
  logic [CW-1:0] InstrCnt;
  logic [23:0] obs;
  int pass_n = 0, total_n = 0, cnt_m = 0;
  proc_ctrl_param #(.REG_AW(RA), .DATA_W(DW), .CNT_W(CW)) dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run), .Gnz(Gnz), .IRin(IRin),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin), .Ain(Ain), .Gin(Gin),
    .AluOp(AluOp), .Done(Done), .Illegal(Illegal), .InstrCnt(InstrCnt)
  );
  always #5 Clock = ~Clock;
  assign obs = {Rout, Gout, DINout, Rin, Ain, Gin, AluOp, Done, Illegal};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [23:0] mk(input logic [7:0] rout, input logic gout, dinout,
                                     input logic [7:0] rin, input logic ain, gin,
                                     input logic [1:0] aluop, input logic done, ill);
    return {rout, gout, dinout, rin, ain, gin, aluop, done, ill};
  endfunction
  function automatic bit is_alu(input logic [2:0] op);
    return op == 3'd1 || op == 3'd2 || op == 3'd5;
  endfunction
  // Expected strobes for execution step k (0 = first cycle after fetch)
  function automatic logic [23:0] expect_step(input logic [2:0] op, x, y, input logic g, input int k);
    logic [7:0] rx, ry;
    logic [1:0] code;
    rx = 8'd1 << x;
    ry = 8'd1 << y;
    code = op == 3'd2 ? 2'b01 : op == 3'd5 ? 2'b10 : 2'b00;
    if (is_alu(op))
      return k == 0 ? mk(rx, 0, 0, 0, 1, 0, 0, 0, 0) :
             k == 1 ? mk(ry, 0, 0, 0, 0, 1, code, 0, 0) : mk(0, 1, 0, rx, 0, 0, 0, 1, 0);
    case (op)
      3'd0: return mk(ry, 0, 0, rx, 0, 0, 0, 1, 0);
      3'd3: return mk(0, 0, 1, rx, 0, 0, 0, 1, 0);
      3'd4: return g ? mk(ry, 0, 0, rx, 0, 0, 0, 1, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      default: return mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    endcase
  endfunction
  task automatic exec(input logic [2:0] op, x, y, input logic g, input logic [8:0] imm, input string tag);
    int n;
    n = is_alu(op) ? 3 : 1;
    DIN = {op, x, y};
    Run = 1'b1;
    Gnz = 1'($urandom);
    #2;
    check($sformatf("%s t0", tag), {IRin, obs}, {1'b1, 24'h0});
    check($sformatf("%s cnt", tag), InstrCnt, cnt_m);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #1;
      DIN = (op == 3'd3 && k == 0) ? imm : 9'($urandom);
      Run = 1'($urandom);
      Gnz = k == 0 ? g : 1'($urandom);
      #2;
      check($sformatf("%s s%0d", tag, k), {IRin, obs}, {1'b0, expect_step(op, x, y, g, k)});
      check($sformatf("%s bus%0d", tag, k), 32'($countones(Rout) + Gout + DINout) <= 1, 1);
    end
    @(posedge Clock);
    #1;
    cnt_m = (cnt_m + 1) % (1 << CW);
    Run = 1'b0;
  endtask
  task automatic idle();
    Run = 1'b0;
    #2;
    check("idle", {IRin, obs}, 25'h0);
    @(posedge Clock);
    #1;
  endtask
  initial begin
    Resetn = 1'b0;
    Run = 1'b0;
    DIN = '0;
    Gnz = 1'b0;
    @(posedge Clock);
    #1;
    check("rst out", {IRin, obs}, 25'h0);
    check("rst cnt", InstrCnt, 0);
    Run = 1'b1;
    #1;
    check("rst irin", IRin, 1);
    Run = 1'b0;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    exec(3'd0, 3'd1, 3'd2, 1'b0, 9'h0, "mv r1,r2");
    exec(3'd1, 3'd3, 3'd4, 1'b0, 9'h0, "add r3,r4");
    exec(3'd2, 3'd3, 3'd4, 1'b0, 9'h0, "sub r3,r4");
    exec(3'd5, 3'd3, 3'd4, 1'b0, 9'h0, "and r3,r4");
    exec(3'd3, 3'd5, 3'd0, 1'b0, 9'h0A5, "mvi r5");
    exec(3'd4, 3'd6, 3'd7, 1'b0, 9'h0, "mvnz g0");
    exec(3'd4, 3'd6, 3'd7, 1'b1, 9'h0, "mvnz g1");
    exec(3'd7, 3'd0, 3'd0, 1'b0, 9'h0, "illegal7");
    idle();
    exec(3'd6, 3'd2, 3'd5, 1'b0, 9'h0, "illegal6");
    exec(3'd1, 3'd2, 3'd2, 1'b0, 9'h0, "add r2,r2");
    // Abort an add in T2 with an asynchronous reset
    DIN = 9'b001_011_100;
    Run = 1'b1;
    repeat (2) begin
      @(posedge Clock);
      #1;
    end
    Run = 1'b1;
    #1;
    Resetn = 1'b0;
    #1;
    check("abort out", {IRin, obs}, {1'b1, 24'h0});
    check("abort cnt", InstrCnt, 0);
    cnt_m = 0;
    Run = 1'b0;
    #1;
    check("abort irin", IRin, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    exec(3'd0, 3'd0, 3'd1, 1'b0, 9'h0, "mv r0,r1");
    for (int i = 0; i < 16; i++) exec(3'd0, 3'(i), 3'(i + 3), 1'b0, 9'h0, $sformatf("wrap%0d", i));
    check("wrap cnt", InstrCnt, 1);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      exec(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 9'($urandom), $sformatf("rnd%0d", i));
    end
    #2;
    check("final cnt", InstrCnt, cnt_m);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
